rgmii_frame_rx: RTL and testbench
=================================

RGMII_FRAME_RX -- requirements
Module: rgmii_frame_rx

Interface
REQ-001 Parameter HDR_SKIP, default 42: header bytes after SFD that are CRC-checked but not written (Eth+IP+UDP).
REQ-002 Parameter MAX_PAYLOAD, default 1472: maximum payload bytes per frame, excluding FCS.
REQ-003 rxclk  in  1: the block's only clock; all logic on rising edge.
REQ-004 rst_n  in  1: asynchronous, active-low reset.
REQ-005 rxctl  in  1: receive data valid, sampled each rxclk.
REQ-006 rxd  in  4: receive nibble, low nibble of each byte first.
REQ-007 wr_en  out  1: one-cycle payload byte write strobe to the dual-port buffer.
REQ-008 wr_addr  out  14: buffer write address.
REQ-009 wr_data  out  8: payload byte.
REQ-010 commit_ptr  out  14: address one past the last byte of the last good frame.
REQ-011 frame_done  out  1: one-cycle pulse at the end of every frame attempt.
REQ-012 frame_ok  out  1: result of the last frame, valid from frame_done and held until the next frame_done.
REQ-013 frame_len  out  14: payload bytes written by the last frame.
REQ-014 err_cnt  out  16: count of bad frames.

Function
REQ-015 Byte assembly: while rxctl=1, nibble pairs form bytes as {second,first}; the nibble phase clears whenever rxctl=0.
REQ-016 States: IDLE, PRE, HDR, PAY, END, DROP.
REQ-017 IDLE -> PRE when rxctl=1.
REQ-018 PRE: byte 0x55 stays in PRE; byte 0xD5 -> HDR, CRC register = 0xFFFFFFFF, counters = 0; any other byte, or more than 15 0x55 bytes -> DROP.
REQ-019 HDR: each byte updates CRC-32 (poly 0x04C11DB7, reflected); after HDR_SKIP bytes -> PAY.
REQ-020 PAY: each byte updates CRC and enters a 4-byte delay line; a byte leaving the delay line produces wr_en=1 with wr_data set to that byte and wr_addr = base + index, so the 4 FCS bytes are never written.
REQ-021 Write latency: wr_en asserts 1 cycle after the byte that pushes the 5th-oldest byte out of the delay line completes.
REQ-022 Addresses wrap modulo 2^14.
REQ-023 rxctl falling in PAY -> END. The frame is good only if the nibble phase is even, at least 4 bytes were received in PAY, and the CRC residue equals 0xC704DD7B.
REQ-024 END lasts one cycle: frame_done=1, frame_ok=good, frame_len=bytes written. If good, commit_ptr and base advance by frame_len; otherwise base is unchanged so the next frame overwrites the bad data. Then -> IDLE.
REQ-025 Written byte count exceeding MAX_PAYLOAD in PAY -> DROP; no further writes occur.
REQ-026 rxctl falling in PRE or HDR -> END with frame_ok=0.
REQ-027 DROP: writes suppressed; on rxctl=0 -> END with frame_ok=0.
REQ-028 rxctl rising during END is treated as a new frame's first nibble (END -> PRE path), and no nibble is lost.
REQ-029 Each bad frame increments err_cnt; err_cnt saturates at 0xFFFF.

Reset
REQ-030 While rst_n=0: state=IDLE; wr_en, frame_done, frame_ok = 0; wr_addr, commit_ptr, frame_len, err_cnt, base = 0; delay line and nibble phase cleared.
REQ-031 Reset mid-frame discards the frame with no frame_done pulse; after release, bytes are ignored until rxctl has been seen low.

Configuration
REQ-032 Macro RGMII_RX_ERR_CNT_EN defined: err_cnt operates per REQ-029.
REQ-033 Macro RGMII_RX_ERR_CNT_EN undefined: err_cnt is constant 0, no counter logic is built, and all other behaviour is identical.

Verification
REQ-034 Frame of 7x55, D5, 42 header bytes, payload 01 02 03 04, correct FCS -> 4 writes at addresses 0..3 with data 01..04; frame_done with frame_ok=1, frame_len=4, commit_ptr=4.
REQ-035 Same frame with the last FCS byte flipped -> 4 writes at 0..3; frame_ok=0; commit_ptr=0; err_cnt=1; the next good frame rewrites from address 0.
REQ-036 Preamble 55 55 A5 -> DROP, no writes; frame_done with frame_ok=0 after rxctl falls.
REQ-037 commit_ptr=16380, good 8-byte payload -> writes at 16380..16383 then 0..3; commit_ptr=4.
REQ-038 Payload of 1473 bytes with good FCS -> 1472 writes, then DROP; frame_ok=0; commit_ptr unchanged.
REQ-039 rst_n pulsed low during PAY -> outputs return to reset values, no frame_done; the following good frame is accepted from address 0.

Source files
------------

// File: rtl/rgmii_frame_rx.sv
// rgmii_frame_rx: RGMII receive path that assembles nibbles into bytes,
// strips preamble and a fixed-length header, checks the Ethernet FCS and
// writes payload bytes (without FCS) into a dual-port buffer.
// Compile-time option: define RGMII_RX_ERR_CNT_EN to build the bad-frame
// counter; without it err_cnt is tied to zero.
//
// state | meaning
// IDLE  | waiting for rxctl (only after rxctl has been seen low since reset)
// PRE   | consuming 0x55 preamble bytes, waiting for SFD 0xD5
// HDR   | header bytes, CRC only, not written
// PAY   | payload + FCS bytes, written through a 4-byte delay line
// END   | one-cycle frame result, commit on success
// DROP  | frame abandoned, waiting for rxctl low
module rgmii_frame_rx #(
  parameter int HDR_SKIP    = 42,
  parameter int MAX_PAYLOAD = 1472
) (
  input  logic        rxclk,
  input  logic        rst_n,
  input  logic        rxctl,
  input  logic [3:0]  rxd,
  output logic        wr_en,
  output logic [13:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [13:0] commit_ptr,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [13:0] frame_len,
  output logic [15:0] err_cnt
);

  localparam int            HW          = (HDR_SKIP > 1) ? $clog2(HDR_SKIP) : 1;
  localparam logic [HW-1:0] HDR_LAST    = HW'(HDR_SKIP - 1);
  localparam logic [13:0]   MAX_LEN     = 14'(MAX_PAYLOAD);
  // CRC register after data+FCS, expressed MSB-first
  localparam logic [31:0]   CRC_RESIDUE = 32'hC704DD7B;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_HDR, S_PAY, S_END, S_DROP
  } state_t;

  state_t          state;
  logic            phase;
  logic [3:0]      nib_lo;
  logic            ctl_q;
  logic            odd_q;
  logic            byte_vld;
  logic [7:0]      byte_q;
  logic            armed;
  logic [31:0]     crc;
  logic [3:0]      pre_cnt;
  logic [HW-1:0]   hdr_cnt;
  logic [2:0]      pay_cnt;
  logic [13:0]     wr_cnt;
  logic [3:0][7:0] dly;
  logic            frame_end;
  logic            crc_good;
  logic            frame_good;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // The shift register holds the CRC LSB-first, so reflect before comparing
  assign crc_good   = (reflect32(crc) == CRC_RESIDUE);
  assign frame_end  = !ctl_q && (state == S_PRE || state == S_HDR ||
                                 state == S_PAY || state == S_DROP);
  assign frame_good = (state == S_PAY) && !odd_q && (pay_cnt == 3'd4) && crc_good;

  // Nibble pairing: low nibble first; phase restarts whenever rxctl is low
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= 1'b0;
      nib_lo   <= '0;
      ctl_q    <= 1'b0;
      odd_q    <= 1'b0;
      byte_vld <= 1'b0;
      byte_q   <= '0;
      armed    <= 1'b0;
    end else begin
      ctl_q    <= rxctl;
      byte_vld <= 1'b0;
      if (rxctl) begin
        phase <= ~phase;
        if (!phase) begin
          nib_lo <= rxd;
        end else begin
          byte_q   <= {rxd, nib_lo};
          byte_vld <= 1'b1;
        end
      end else begin
        phase <= 1'b0;
        odd_q <= phase;
        armed <= 1'b1;
      end
    end
  end

  // Frame FSM with registered buffer-write and result outputs
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      commit_ptr <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      frame_len  <= '0;
      crc        <= '1;
      pre_cnt    <= '0;
      hdr_cnt    <= '0;
      pay_cnt    <= '0;
      wr_cnt     <= '0;
      dly        <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      if (frame_end) begin
        // commit_ptr doubles as the write base: a bad frame leaves it alone
        state      <= S_END;
        frame_done <= 1'b1;
        frame_ok   <= frame_good;
        frame_len  <= wr_cnt;
        if (frame_good) commit_ptr <= commit_ptr + wr_cnt;
      end else begin
        unique case (state)
          S_IDLE: begin
            pre_cnt <= '0;
            pay_cnt <= '0;
            wr_cnt  <= '0;
            if (ctl_q && armed) state <= S_PRE;
          end
          S_PRE: begin
            if (byte_vld) begin
              if (byte_q == 8'hD5) begin
                state   <= S_HDR;
                crc     <= '1;
                hdr_cnt <= '0;
                pay_cnt <= '0;
                wr_cnt  <= '0;
                dly     <= '0;
              end else if (byte_q == 8'h55 && pre_cnt != 4'hF) begin
                pre_cnt <= pre_cnt + 4'd1;
              end else begin
                state <= S_DROP;
              end
            end
          end
          S_HDR: begin
            if (byte_vld) begin
              crc <= crc_byte(crc, byte_q);
              if (hdr_cnt == HDR_LAST) state <= S_PAY;
              else                     hdr_cnt <= hdr_cnt + HW'(1);
            end
          end
          S_PAY: begin
            if (byte_vld) begin
              crc <= crc_byte(crc, byte_q);
              dly <= {dly[2:0], byte_q};
              if (pay_cnt != 3'd4) begin
                pay_cnt <= pay_cnt + 3'd1;
              end else if (wr_cnt == MAX_LEN) begin
                state <= S_DROP;
              end else begin
                wr_en   <= 1'b1;
                wr_data <= dly[3];
                wr_addr <= commit_ptr + wr_cnt;
                wr_cnt  <= wr_cnt + 14'd1;
              end
            end
          end
          S_END: begin
            pre_cnt <= '0;
            pay_cnt <= '0;
            wr_cnt  <= '0;
            // rxctl already high again: this is the next frame's first nibble
            state   <= ctl_q ? S_PRE : S_IDLE;
          end
          S_DROP: begin
            state <= S_DROP;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef RGMII_RX_ERR_CNT_EN
  // Count failed frame attempts, holding at all-ones
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (frame_end && !frame_good && err_cnt != 16'hFFFF) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_rgmii_frame_rx.sv
// Testbench for rgmii_frame_rx: frame-level reference model (expected writes
// and per-frame results in queues) checked every cycle, plus directed cases.
module tb_rgmii_frame_rx;

  localparam int HDR_SKIP    = 42;
  localparam int MAX_PAYLOAD = 1472;
`ifdef RGMII_RX_ERR_CNT_EN
  localparam int ERR_ON = 1;
`else
  localparam int ERR_ON = 0;
`endif

  typedef logic [7:0] bq_t[$];
  typedef struct { logic [13:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic ok; logic [13:0] len; logic [13:0] cptr; logic [15:0] err; } res_t;

  logic        rxclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxctl = 1'b0;
  logic [3:0]  rxd   = 4'h0;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [7:0]  wr_data;
  logic [13:0] commit_ptr;
  logic        frame_done;
  logic        frame_ok;
  logic [13:0] frame_len;
  logic [15:0] err_cnt;

  rgmii_frame_rx #(.HDR_SKIP(HDR_SKIP), .MAX_PAYLOAD(MAX_PAYLOAD)) dut (
    .rxclk(rxclk), .rst_n(rst_n), .rxctl(rxctl), .rxd(rxd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit_ptr(commit_ptr), .frame_done(frame_done), .frame_ok(frame_ok),
    .frame_len(frame_len), .err_cnt(err_cnt)
  );

  always #5 rxclk = ~rxclk;

  int   tests = 0;
  int   fails = 0;
  wr_t  exp_wr[$];
  res_t exp_res[$];
  int   m_base = 0;
  int   m_err  = 0;
  int   n_wr   = 0;
  logic held_ok   = 1'b0;
  logic [13:0] held_cptr = '0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Standard Ethernet CRC-32 (the value transmitted as FCS, LSB byte first)
  function automatic logic [31:0] crc32(input bq_t q);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t rand_pay(input int n);
    bq_t p;
    for (int i = 0; i < n; i++) p.push_back(8'($urandom));
    return p;
  endfunction

  function automatic bq_t make_frame(input int npre, input bq_t pay, input bit corrupt);
    bq_t q, d;
    logic [31:0] f;
    for (int i = 0; i < npre; i++) q.push_back(8'h55);
    q.push_back(8'hD5);
    for (int i = 0; i < HDR_SKIP; i++) d.push_back(8'($urandom));
    foreach (pay[i]) d.push_back(pay[i]);
    f = crc32(d);
    for (int i = 0; i < 4; i++) d.push_back(f[8*i +: 8]);
    if (corrupt) d[d.size()-1] = d[d.size()-1] ^ 8'h80;
    foreach (d[i]) q.push_back(d[i]);
    return q;
  endfunction

  // Frame-level rules: what the buffer sees and what the result must be
  function automatic void model_frame(input bq_t q, input bit odd);
    int   i, n55, n, nw;
    bit   good;
    bq_t  body, data;
    logic [31:0] f;
    res_t r;
    wr_t  w;
    good = 0; nw = 0; n55 = 0; i = 0;
    while (i < q.size() && q[i] == 8'h55) begin i++; n55++; end
    if (n55 <= 15 && i < q.size() && q[i] == 8'hD5) begin
      for (int k = i + 1; k < q.size(); k++) body.push_back(q[k]);
      n = body.size() - HDR_SKIP;
      if (n >= 4) begin
        nw = n - 4;
        if (nw > MAX_PAYLOAD) begin
          nw = MAX_PAYLOAD;
        end else begin
          for (int k = 0; k < body.size() - 4; k++) data.push_back(body[k]);
          f = crc32(data);
          good = !odd;
          for (int k = 0; k < 4; k++)
            if (body[body.size()-4+k] != f[8*k +: 8]) good = 0;
        end
      end
      for (int k = 0; k < nw; k++) begin
        w.addr = 14'((m_base + k) % 16384);
        w.data = body[HDR_SKIP + k];
        exp_wr.push_back(w);
      end
    end
    if (good) m_base = (m_base + nw) % 16384;
    else if (m_err < 65535) m_err++;
    r.ok = good; r.len = 14'(nw); r.cptr = 14'(m_base); r.err = 16'(m_err * ERR_ON);
    exp_res.push_back(r);
  endfunction

  task automatic drive(input bq_t q, input bit odd, input int gap);
    foreach (q[i]) begin
      @(negedge rxclk); rxctl = 1'b1; rxd = q[i][3:0];
      @(negedge rxclk); rxd = q[i][7:4];
    end
    if (odd) begin
      @(negedge rxclk); rxctl = 1'b1; rxd = 4'($urandom);
    end
    @(negedge rxclk); rxctl = 1'b0; rxd = 4'h0;
    repeat (gap - 1) @(negedge rxclk);
  endtask

  task automatic send_frame(input bq_t q, input bit odd, input int gap);
    model_frame(q, odd);
    drive(q, odd, gap);
  endtask

  // Per-cycle comparison against the model queues
  initial begin
    wr_t  w;
    res_t r;
    forever begin
      @(posedge rxclk); #1;
      if (!rst_n) begin
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_commit_ptr", 32'(commit_ptr), 0);
        held_ok = 1'b0; held_cptr = '0;
      end else begin
        if (wr_en) begin
          n_wr++;
          if (exp_wr.size() == 0) begin
            check("wr_unexpected", 32'(wr_en), 0);
          end else begin
            w = exp_wr.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(w.addr));
            check("wr_data", 32'(wr_data), 32'(w.data));
          end
        end
        if (frame_done) begin
          if (exp_res.size() == 0) begin
            check("done_unexpected", 32'(frame_done), 0);
          end else begin
            r = exp_res.pop_front();
            check("frame_ok", 32'(frame_ok), 32'(r.ok));
            check("frame_len", 32'(frame_len), 32'(r.len));
            check("commit_ptr", 32'(commit_ptr), 32'(r.cptr));
            check("err_cnt", 32'(err_cnt), 32'(r.err));
            held_ok = r.ok; held_cptr = r.cptr;
          end
        end else begin
          check("frame_ok_hold", 32'(frame_ok), 32'(held_ok));
          check("commit_hold", 32'(commit_ptr), 32'(held_cptr));
        end
      end
    end
  end

  initial begin
    bq_t q, p;
    int  nw0, cp0, kind, rem, k, cut;
    bit  odd;

    p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("crc_pin", crc32(p), 32'hCBF43926);

    repeat (4) @(negedge rxclk);
    rst_n = 1'b1;
    repeat (3) @(negedge rxclk);
    check("reset_wr_addr", 32'(wr_addr), 0);
    check("reset_frame_len", 32'(frame_len), 0);
    check("reset_frame_ok", 32'(frame_ok), 0);
    check("reset_err_cnt", 32'(err_cnt), 0);

    // Bad FCS: data still lands at 0..3 but is not committed
    p = '{8'h01, 8'h02, 8'h03, 8'h04};
    nw0 = n_wr;
    send_frame(make_frame(7, p, 1'b1), 1'b0, 4);
    repeat (4) @(negedge rxclk);
    check("badfcs_writes", 32'(n_wr - nw0), 4);
    check("badfcs_ok", 32'(frame_ok), 0);
    check("badfcs_commit", 32'(commit_ptr), 0);
    check("badfcs_err", 32'(err_cnt), 32'(ERR_ON));

    // Good frame overwrites from address 0
    nw0 = n_wr;
    send_frame(make_frame(7, p, 1'b0), 1'b0, 4);
    repeat (4) @(negedge rxclk);
    check("good4_writes", 32'(n_wr - nw0), 4);
    check("good4_ok", 32'(frame_ok), 1);
    check("good4_len", 32'(frame_len), 4);
    check("good4_commit", 32'(commit_ptr), 4);

    // Bad preamble byte
    q = '{8'h55, 8'h55, 8'hA5};
    p = rand_pay(10);
    foreach (p[i]) q.push_back(p[i]);
    nw0 = n_wr;
    send_frame(q, 1'b0, 3);
    repeat (4) @(negedge rxclk);
    check("badpre_writes", 32'(n_wr - nw0), 0);
    check("badpre_ok", 32'(frame_ok), 0);
    check("badpre_commit", 32'(commit_ptr), 4);

    // Randomized mix, gaps down to one cycle for back-to-back frames
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 9);
      odd  = (kind == 1);
      p = rand_pay($urandom_range(0, 64));
      if (kind == 4) q = make_frame($urandom_range(16, 18), p, 1'b0);
      else           q = make_frame($urandom_range(1, 15), p, kind == 0);
      if (kind == 2) begin
        cut = $urandom_range(1, q.size() - 1);
        while (q.size() > cut) void'(q.pop_back());
      end
      if (kind == 3) q[$urandom_range(0, 1)] = 8'h5A;
      send_frame(q, odd, $urandom_range(1, 4));
    end

    // Payload length boundary: exactly MAX is good, one more is dropped
    send_frame(make_frame(7, rand_pay(MAX_PAYLOAD), 1'b0), 1'b0, 2);
    repeat (4) @(negedge rxclk);
    check("max_ok", 32'(frame_ok), 1);
    check("max_len", 32'(frame_len), 32'(MAX_PAYLOAD));
    cp0 = commit_ptr;
    nw0 = n_wr;
    send_frame(make_frame(7, rand_pay(MAX_PAYLOAD + 1), 1'b0), 1'b0, 2);
    repeat (4) @(negedge rxclk);
    check("ovf_writes", 32'(n_wr - nw0), 32'(MAX_PAYLOAD));
    check("ovf_ok", 32'(frame_ok), 0);
    check("ovf_commit", 32'(commit_ptr), 32'(cp0));

    // Fill the buffer up to 16380, then wrap with an 8-byte payload
    rem = (16380 - m_base + 16384) % 16384;
    while (rem > 0) begin
      k = (rem > MAX_PAYLOAD) ? MAX_PAYLOAD : rem;
      if (k < 4 && rem > k) k = 4;
      send_frame(make_frame(7, rand_pay(k), 1'b0), 1'b0, 1);
      rem -= k;
    end
    repeat (4) @(negedge rxclk);
    check("fill_commit", 32'(commit_ptr), 16380);
    nw0 = n_wr;
    send_frame(make_frame(7, rand_pay(8), 1'b0), 1'b0, 2);
    repeat (4) @(negedge rxclk);
    check("wrap_writes", 32'(n_wr - nw0), 8);
    check("wrap_commit", 32'(commit_ptr), 4);

    // Reset during PAY (3 payload bytes in, nothing written yet)
    q = make_frame(7, rand_pay(10), 1'b0);
    while (q.size() > 8 + HDR_SKIP + 3) void'(q.pop_back());
    foreach (q[i]) begin
      @(negedge rxclk); rxctl = 1'b1; rxd = q[i][3:0];
      @(negedge rxclk); rxd = q[i][7:4];
    end
    @(negedge rxclk); rst_n = 1'b0;
    m_base = 0; m_err = 0;
    repeat (3) @(negedge rxclk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rxd = 4'($urandom);
      @(negedge rxclk);
    end
    rxctl = 1'b0; rxd = 4'h0;
    repeat (4) @(negedge rxclk);
    check("rstpay_commit", 32'(commit_ptr), 0);
    check("rstpay_len", 32'(frame_len), 0);
    check("rstpay_ok", 32'(frame_ok), 0);
    check("rstpay_err", 32'(err_cnt), 0);
    check("rstpay_no_result", 32'(exp_res.size()), 0);
    send_frame(make_frame(7, rand_pay(6), 1'b0), 1'b0, 4);
    repeat (4) @(negedge rxclk);
    check("after_rst_ok", 32'(frame_ok), 1);
    check("after_rst_commit", 32'(commit_ptr), 6);

    repeat (10) @(negedge rxclk);
    check("leftover_writes", 32'(exp_wr.size()), 0);
    check("leftover_results", 32'(exp_res.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
